// File: rtl/dec_bit_packer_pkg.sv
// Shared constants and types for the decoder output bit packer.
package dec_bit_packer_pkg;

    // Register-exchange depth; the first DEC_WARMUP bits of every frame are unreliable.
    localparam int DEC_WARMUP     = 60;
    localparam int DEC_WORD_W     = 8;
    localparam int DEC_FIFO_DEPTH = 4;
    localparam int DEC_BITS_W     = 16;

    typedef enum logic {
        S_WARM,
        S_PACK
    } pack_state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [DEC_BITS_W-1:0] sat_inc(input logic [DEC_BITS_W-1:0] value);
        if (value == {DEC_BITS_W{1'b1}}) begin
            return value;
        end
        return value + DEC_BITS_W'(1);
    endfunction

endpackage

// File: rtl/dec_bit_packer_if.sv
// Bit-stream input and word-stream output of the decoder packer, bundled.
// The master modport is the packer; the slave modport is its environment.
interface dec_bit_packer_if #(
    parameter int WORD_W = 8
);
    // Serial decoded-bit stream from the path-metric stage (no back-pressure).
    logic              valid_i;
    logic              data_i;
    logic              last_i;

    // Packed word stream towards the sink (valid/ready).
    logic [WORD_W-1:0] word_o;
    logic              word_last_o;
    logic              word_valid_o;
    logic              word_ready_i;

    modport master (
        input  valid_i,
        input  data_i,
        input  last_i,
        input  word_ready_i,
        output word_o,
        output word_last_o,
        output word_valid_o
    );

    modport slave (
        output valid_i,
        output data_i,
        output last_i,
        output word_ready_i,
        input  word_o,
        input  word_last_o,
        input  word_valid_o
    );

endinterface

// File: rtl/dec_out_fifo.sv
// Small synchronous FIFO buffering packed words towards the sink.
// A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module dec_out_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic do_push;
    logic do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head word; forced to zero while empty so the stale array never leaks out.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write port.
    // NOTE: the storage array has no reset; the occupancy count alone decides which
    // entries are meaningful, and the head output is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dec_bit_packer.sv
// Decoder output packer: drops the register-exchange warm-up bits of every frame,
// packs the remaining bits MSB-first into words and queues them for the sink.
module dec_bit_packer
    import dec_bit_packer_pkg::*;
#(
    parameter int WORD_W     = DEC_WORD_W,
    parameter int WARMUP     = DEC_WARMUP,
    parameter int FIFO_DEPTH = DEC_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    dec_bit_packer_if.master      bus,
    output logic                  overflow_o,
    output logic [DEC_BITS_W-1:0] bits_o
);

    localparam int CNT_W  = $clog2(WORD_W);
    localparam int WARM_W = $clog2(WARMUP + 1);

    pack_state_e           state_q;
    logic [WARM_W-1:0]     warm_cnt_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [WORD_W-1:0]     sr_q;
    logic                  overflow_q;
    logic [DEC_BITS_W-1:0] bits_q;

    logic [WORD_W-1:0]     sr_d;
    logic                  word_done;
    logic [WORD_W-1:0]     push_word;
    logic                  drop_word;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WORD_W:0]       fifo_head;

    // Next shift-register value, word-complete strobe and left-aligned push word.
    // NOTE: every signal gets a default at the top of the block so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        sr_d      = {sr_q[WORD_W-2:0], bus.data_i};
        word_done = 1'b0;
        push_word = '0;
        drop_word = 1'b0;
        if (!flush_i && bus.valid_i && (state_q == S_PACK)) begin
            word_done = (bit_cnt_q == CNT_W'(WORD_W - 1)) || bus.last_i;
        end
        // bit_cnt_q+1 fresh bits sit in the LSBs of sr_d; shifting pushes older bits out
        // the top and zero-pads a partial word.
        push_word = sr_d << (CNT_W'(WORD_W - 1) - bit_cnt_q);
        // A full FIFO only frees a slot this cycle if the sink takes its head.
        drop_word = word_done && fifo_full && !bus.word_ready_i;
    end

    // Warm-up / pack state machine with its counters, shift register and status flags.
    // NOTE: state is updated with non-blocking assignments only, so every branch
    // reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_WARM;
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            overflow_q <= 1'b0;
            bits_q     <= '0;
        end else if (flush_i) begin
            state_q    <= S_WARM;
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            overflow_q <= 1'b0;
            bits_q     <= '0;
        end else begin
            if (drop_word) begin
                overflow_q <= 1'b1;
            end
            if (bus.valid_i) begin
                case (state_q)
                    S_WARM: begin
                        if (bus.last_i) begin
                            // Frame ended during warm-up: nothing to emit, re-warm.
                            warm_cnt_q <= '0;
                        end else if (warm_cnt_q == WARM_W'(WARMUP - 1)) begin
                            warm_cnt_q <= warm_cnt_q + WARM_W'(1);
                            state_q    <= S_PACK;
                        end else begin
                            warm_cnt_q <= warm_cnt_q + WARM_W'(1);
                        end
                    end
                    S_PACK: begin
                        sr_q   <= sr_d;
                        bits_q <= sat_inc(bits_q);
                        if (word_done) begin
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                        if (bus.last_i) begin
                            state_q    <= S_WARM;
                            warm_cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= S_WARM;
                    end
                endcase
            end
        end
    end

    dec_out_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (word_done),
        .data_i  ({bus.last_i, push_word}),
        .pop_i   (bus.word_ready_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.word_o       = fifo_head[WORD_W-1:0];
    assign bus.word_last_o  = fifo_head[WORD_W];
    assign bus.word_valid_o = !fifo_empty;
    assign overflow_o       = overflow_q;
    assign bits_o           = bits_q;

endmodule
